systolic_array_core: RTL and testbench

Output-stationary DIM×DIM systolic matrix-multiply array of signed multiply-accumulate processing elements (PEs). Each PE holds one element of the result matrix C. The host preloads C row by row, streams skewed rows of A and columns of B into the array edges, and reads C back one row per access. The block sits between the host's operand buffers and the result buffer as the compute core of the matrix engine.

---
 rtl/systolic_array_core.sv | 85 ++++++++
 tb/tb_systolic_array_core.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_core.sv
// Output-stationary DIM x DIM signed MAC array: A flows right, B flows down,
// each PE accumulates its C element in place; C rows are host-writable and readable.
module systolic_array_core #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8,
    parameter int ROWBITS = $clog2(DIM)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic                                 WrEn,
    input  logic [ROWBITS-1:0]                   Crow,
    input  logic signed [DIM-1:0][BITS_AB-1:0]   A,
    input  logic signed [DIM-1:0][BITS_AB-1:0]   B,
    input  logic signed [DIM-1:0][BITS_C-1:0]    Cin,
    output logic signed [DIM-1:0][BITS_C-1:0]    Cout
);

    logic signed [BITS_AB-1:0] a_reg [DIM][DIM];
    logic signed [BITS_AB-1:0] b_reg [DIM][DIM];
    logic signed [BITS_AB-1:0] a_in  [DIM][DIM];
    logic signed [BITS_AB-1:0] b_in  [DIM][DIM];
    logic signed [BITS_C-1:0]  acc   [DIM][DIM];

    // Full-precision product, sign-extended then wrapped to the accumulator width.
    function automatic logic signed [BITS_C-1:0] mac_wrap(
        input logic signed [BITS_C-1:0]  acc_v,
        input logic signed [BITS_AB-1:0] a_v,
        input logic signed [BITS_AB-1:0] b_v
    );
        logic signed [2*BITS_AB-1:0]        prod;
        logic signed [2*BITS_AB+BITS_C-1:0] prod_ext;
        prod     = $signed({{BITS_AB{a_v[BITS_AB-1]}}, a_v}) *
                   $signed({{BITS_AB{b_v[BITS_AB-1]}}, b_v});
        prod_ext = {{BITS_C{prod[2*BITS_AB-1]}}, prod};
        return acc_v + prod_ext[BITS_C-1:0];
    endfunction

    // Operand routing: edge PEs take the ports, interior PEs take their neighbour's register.
    for (genvar r = 0; r < DIM; r++) begin : g_row
        for (genvar c = 0; c < DIM; c++) begin : g_col
            if (c == 0) begin : g_a_edge
                assign a_in[r][c] = $signed(A[r]);
            end else begin : g_a_int
                assign a_in[r][c] = a_reg[r][c-1];
            end
            if (r == 0) begin : g_b_edge
                assign b_in[r][c] = $signed(B[c]);
            end else begin : g_b_int
                assign b_in[r][c] = b_reg[r-1][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                if (rst) begin
                    a_reg[r][c] <= '0;
                    b_reg[r][c] <= '0;
                    acc[r][c]   <= '0;
                end else begin
                    if (en) begin
                        a_reg[r][c] <= a_in[r][c];
                        b_reg[r][c] <= b_in[r][c];
                    end
                    // A host write freezes accumulation across the whole array for that cycle.
                    if (WrEn) begin
                        if (ROWBITS'(r) == Crow)
                            acc[r][c] <= $signed(Cin[c]);
                    end else if (en) begin
                        acc[r][c] <= mac_wrap(acc[r][c], a_in[r][c], b_in[r][c]);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < DIM; c++)
            Cout[c] = acc[Crow][c];
    end

endmodule

// File: tb/tb_systolic_array_core.sv
// Directed bench for systolic_array_core: reset, preload, skewed matmuls, hold and write priority.
module tb_systolic_array_core;
    localparam int DIM = 8;
    localparam int BA  = 8;
    localparam int BC  = 16;

    logic clk = 1'b0;
    logic rst, en, WrEn;
    logic [2:0] Crow;
    logic signed [DIM-1:0][BA-1:0] A, B;
    logic signed [DIM-1:0][BC-1:0] Cin, Cout;

    always #5 clk = ~clk;

    systolic_array_core #(.BITS_AB(BA), .BITS_C(BC), .DIM(DIM)) dut (
        .clk(clk), .rst(rst), .en(en), .WrEn(WrEn), .Crow(Crow),
        .A(A), .B(B), .Cin(Cin), .Cout(Cout)
    );

    logic signed [7:0]  ma [8][8];
    logic signed [7:0]  mb [8][8];
    logic signed [15:0] exp_c [8][8];
    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        string name;
        int    a_fill;
        int    b_fill;
        int    exp;
    } uvec_t;
    uvec_t tbl [7];

    task automatic check_all(input string name);
        logic signed [15:0] got;
        for (int r = 0; r < DIM; r++) begin
            int bad_c;
            logic signed [15:0] bad_got, bad_exp;
            bad_c = -1; bad_got = '0; bad_exp = '0;
            @(negedge clk);
            Crow = 3'(r);
            #1;
            for (int c = 0; c < DIM; c++) begin
                got = $signed(Cout[c]);
                if (got !== exp_c[r][c] && bad_c < 0) begin
                    bad_c = c; bad_got = got; bad_exp = exp_c[r][c];
                end
            end
            total_cnt++;
            if (bad_c < 0) pass_cnt++;
            else $display("FAIL %s row %0d col %0d: got %0d expected %0d",
                          name, r, bad_c, bad_got, bad_exp);
        end
    endtask

    task automatic set_exp_const(input int v);
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                exp_c[r][c] = 16'(v);
    endtask

    task automatic set_exp_pattern();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                exp_c[r][c] = 16'(16 * r + c);
    endtask

    // Adds A x B (wrapped to 16 bits) onto whatever exp_c already holds.
    task automatic add_matmul_exp();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                int s;
                s = int'(exp_c[r][c]);
                for (int k = 0; k < DIM; k++)
                    s += int'(ma[r][k]) * int'(mb[k][c]);
                exp_c[r][c] = 16'(s);
            end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic preload(input int mode);
        for (int r = 0; r < DIM; r++) begin
            @(negedge clk);
            WrEn = 1'b1;
            Crow = 3'(r);
            for (int c = 0; c < DIM; c++)
                Cin[c] = (mode == 0) ? 16'sd0 : 16'(16 * r + c);
        end
        @(negedge clk);
        WrEn = 1'b0;
        Cin  = '0;
    endtask

    task automatic fill_random();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                ma[r][c] = 8'($urandom_range(0, 255));
                mb[r][c] = 8'($urandom_range(0, 255));
            end
    endtask

    task automatic fill_const(input int av, input int bv);
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                ma[r][c] = 8'(av);
                mb[r][c] = 8'(bv);
            end
    endtask

    // Streams skewed operands for 3*DIM-2 enabled cycles; optionally freezes with en=0
    // (and garbage on the operand ports) for hold_len cycles before cycle hold_at.
    task automatic run_mm(input int hold_at, input int hold_len);
        for (int t = 0; t < 3 * DIM - 2; t++) begin
            if (t == hold_at) begin
                for (int h = 0; h < hold_len; h++) begin
                    @(negedge clk);
                    en = 1'b0;
                    for (int i = 0; i < DIM; i++) begin
                        A[i] = 8'($urandom_range(0, 255));
                        B[i] = 8'($urandom_range(0, 255));
                    end
                end
            end
            @(negedge clk);
            en = 1'b1;
            for (int i = 0; i < DIM; i++) begin
                A[i] = (t - i >= 0 && t - i < DIM) ? ma[i][t - i] : 8'sd0;
                B[i] = (t - i >= 0 && t - i < DIM) ? mb[t - i][i] : 8'sd0;
            end
        end
        @(negedge clk);
        en = 1'b0;
        A  = '0;
        B  = '0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; WrEn = 1'b0; Crow = '0;
        A = '0; B = '0; Cin = '0;

        tbl[0] = '{"neg128_neg128", -128, -128,     0};
        tbl[1] = '{"neg128_pos127", -128,  127,  1024};
        tbl[2] = '{"pos127_pos127",  127,  127, -2040};
        tbl[3] = '{"ones",             1,    1,     8};
        tbl[4] = '{"two_neg3",         2,   -3,   -48};
        tbl[5] = '{"neg1_one",        -1,    1,    -8};
        tbl[6] = '{"zero_a",           0,    5,     0};

        do_reset();
        set_exp_const(0);
        check_all("reset");

        preload(0);
        set_exp_const(0);
        check_all("preload_zero");

        preload(1);
        set_exp_pattern();
        check_all("preload_pattern");

        do_reset();
        set_exp_const(0);
        check_all("reset_clears");

        // Identity A: result must equal B.
        preload(0);
        fill_random();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                ma[r][c] = (r == c) ? 8'sd1 : 8'sd0;
        run_mm(-1, 0);
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                exp_c[r][c] = 16'(mb[r][c]);
        check_all("identity");

        for (int i = 0; i < 7; i++) begin
            preload(0);
            fill_const(tbl[i].a_fill, tbl[i].b_fill);
            run_mm(-1, 0);
            set_exp_const(tbl[i].exp);
            check_all(tbl[i].name);
        end

        for (int it = 0; it < 16; it++) begin
            preload(0);
            fill_random();
            run_mm(-1, 0);
            set_exp_const(0);
            add_matmul_exp();
            check_all("random");
        end

        // Accumulate on top of a nonzero preload.
        preload(1);
        fill_random();
        run_mm(-1, 0);
        set_exp_pattern();
        add_matmul_exp();
        check_all("preload_plus_ab");

        // Freeze mid-stream for 3 cycles.
        preload(0);
        fill_random();
        run_mm(9, 3);
        set_exp_const(0);
        add_matmul_exp();
        check_all("hold_en");

        // Write with en=1: row 2 takes Cin, no PE accumulates, operands still advance.
        do_reset();
        preload(1);
        @(negedge clk);
        WrEn = 1'b1; en = 1'b1; Crow = 3'd2;
        for (int c = 0; c < DIM; c++) Cin[c] = 16'(100 + c);
        A = '0; B = '0;
        A[0] = 8'sd2; B[0] = 8'sd5;
        @(negedge clk);
        WrEn = 1'b0; Cin = '0;
        A = '0; B = '0;
        B[1] = 8'sd7;
        @(negedge clk);
        en = 1'b0; B = '0;
        set_exp_pattern();
        for (int c = 0; c < DIM; c++) exp_c[2][c] = 16'(100 + c);
        exp_c[0][1] = 16'sd15;
        check_all("wren_priority");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
